// File: rtl/ndp_pkg.sv
// Shared definitions for the NDP result path: drain FSM encoding, the default
// output bus width and the matrix geometry helpers used by loader and drain.
package ndp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2
    } drain_state_e;

    localparam int BUS_WIDTH_DEFAULT = 32;

    // Total result rows across the stacked systolic arrays.
    function automatic int calc_rows(input int sys_height, input int arr_height);
        return sys_height * arr_height;
    endfunction

    // Total result columns across the side-by-side systolic arrays.
    function automatic int calc_cols(input int sys_width, input int arr_width);
        return sys_width * arr_width;
    endfunction

    // Number of bus words needed to carry the whole result matrix.
    function automatic int calc_n_words(input int rows, input int cols,
                                        input int width, input int bus_width);
        return (rows * cols * width) / bus_width;
    endfunction

    // Index width for a counter over n entries, never narrower than one bit.
    function automatic int calc_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ndp_rise_detect.sv
// Rising-edge detector for the core's done level. The history register resets
// high so a flag that is already asserted when reset releases is ignored.
module ndp_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic flag,
    output logic rise
);

    logic prev_reg;

    // Sample the flag every cycle to remember its previous level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= flag;
        end
    end

    assign rise = flag & ~prev_reg;

endmodule

// File: rtl/ndp_result_drain.sv
// Captures the NDP_core result matrix on a done-flag rise and streams it out as
// BUS_WIDTH words over valid/ready, then pulses result_taken for one cycle.
module ndp_result_drain
    import ndp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int SYS_HEIGHT = 1,
    parameter int SYS_WIDTH  = 1,
    parameter int BUS_WIDTH  = BUS_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 calc_done_flag,
    input  logic [SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH-1:0] in_c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 result_taken,
    output logic                 overrun
);

    localparam int ROWS    = calc_rows(SYS_HEIGHT, ARR_HEIGHT);
    localparam int COLS    = calc_cols(SYS_WIDTH, ARR_WIDTH);
    localparam int MAT_W   = ROWS * COLS * WIDTH;
    localparam int N_WORDS = calc_n_words(ROWS, COLS, WIDTH, BUS_WIDTH);
    localparam int WIDX_W  = calc_idx_width(N_WORDS);
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(N_WORDS - 1);

    drain_state_e        state_reg, state_next;
    logic [MAT_W-1:0]    buf_reg;
    logic [WIDX_W-1:0]   widx_reg, widx_next;
    logic                overrun_reg;
    logic                capture;
    logic                rise;
    logic [BUS_WIDTH-1:0] word_arr [N_WORDS];

    ndp_rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .flag  (calc_done_flag),
        .rise  (rise)
    );

    // Slice the capture buffer into bus words; word w is the w-th BUS_WIDTH chunk.
    generate
        for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_words
            assign word_arr[gi] = buf_reg[gi*BUS_WIDTH +: BUS_WIDTH];
        end
    endgenerate

    // State, word index and capture buffer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            widx_reg  <= '0;
            buf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            widx_reg  <= widx_next;
            if (capture) begin
                buf_reg <= in_c;
            end
        end
    end

    // Sticky overrun: a new result showed up while the previous one was draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_reg <= 1'b0;
        end else if (rise && (state_reg != ST_IDLE)) begin
            overrun_reg <= 1'b1;
        end
    end

    // Next-state logic; in SEND out_valid is 1, so out_ready alone marks a handshake.
    always_comb begin
        state_next = state_reg;
        widx_next  = widx_reg;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rise) begin
                    capture    = 1'b1;
                    widx_next  = '0;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (widx_reg == LAST_IDX) begin
                        state_next = ST_ACK;
                    end else begin
                        widx_next = widx_reg + 1'b1;
                    end
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only, so they drop the moment reset asserts.
    always_comb begin
        out_valid    = (state_reg == ST_SEND);
        out_data     = '0;
        out_last     = 1'b0;
        if (state_reg == ST_SEND) begin
            out_data = word_arr[widx_reg];
            out_last = (widx_reg == LAST_IDX);
        end
        busy         = (state_reg == ST_SEND) || (state_reg == ST_ACK);
        result_taken = (state_reg == ST_ACK);
        overrun      = overrun_reg;
    end

endmodule

// File: tb/tb_ndp_result_drain.sv
// Scoreboard bench for ndp_result_drain: expected words are queued when a
// matrix is presented and popped as the DUT hands words over.
module tb_ndp_result_drain;

    logic         clk;
    logic         reset;
    logic         calc_done_flag;
    logic [255:0] in_c;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         busy;
    logic         result_taken;
    logic         overrun;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];

    ndp_result_drain dut (
        .clk            (clk),
        .reset          (reset),
        .calc_done_flag (calc_done_flag),
        .in_c           (in_c),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .result_taken   (result_taken),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element i of the matrix is base+i; word w pairs element 2w (low) with 2w+1 (high).
    task automatic load_matrix(input logic [15:0] base, input bit push);
        logic [15:0] lo;
        logic [15:0] hi;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            in_c[i*16 +: 16] = base + 16'(i);
        end
        if (push) begin
            for (int w = 0; w < 8; w++) begin
                lo = base + 16'(2*w);
                hi = base + 16'(2*w + 1);
                e.data = {hi, lo};
                e.last = (w == 7);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic apply_reset;
        @(negedge clk);
        reset = 1'b0;
        calc_done_flag = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (result_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b expected 0", result_taken); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        $display("test_reset: outputs idle after reset");
    endtask

    task automatic test_basic;
        int cyc;
        int n_acc;
        exp_t e;
        cyc = 0;
        n_acc = 0;
        load_matrix(16'h3C00, 1'b1);
        out_ready = 1'b1;
        calc_done_flag = 1'b1;
        while (sb_q.size() != 0 && cyc < 100) begin
            @(negedge clk); #1;
            if (out_valid && out_ready) begin
                e = sb_q.pop_front();
                checks++; if (out_data !== e.data) begin errors++; $display("FAIL basic_data: got %h expected %h", out_data, e.data); end
                checks++; if (out_last !== e.last) begin errors++; $display("FAIL basic_last: got %b expected %b", out_last, e.last); end
                checks++; if (cyc != n_acc) begin errors++; $display("FAIL basic_timing: word %0d at cycle %0d expected cycle %0d", n_acc, cyc, n_acc); end
                $display("basic: word %0d data %h last %b", n_acc, out_data, out_last);
                n_acc++;
            end
            cyc++;
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL basic_timeout: %0d words left expected 0", sb_q.size()); end
        sb_q.delete();
        @(negedge clk); #1;
        checks++; if (result_taken !== 1'b1) begin errors++; $display("FAIL basic_taken: got %b expected 1", result_taken); end
        @(negedge clk); #1;
        checks++; if (result_taken !== 1'b0) begin errors++; $display("FAIL basic_taken_pulse: got %b expected 0", result_taken); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
        calc_done_flag = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_backpressure;
        int cyc;
        int n_acc;
        bit stall_pending;
        bit taken_seen;
        logic [31:0] held;
        exp_t e;
        cyc = 0;
        n_acc = 0;
        stall_pending = 0;
        taken_seen = 0;
        held = '0;
        load_matrix(16'h3C00, 1'b1);
        calc_done_flag = 1'b1;
        while (sb_q.size() != 0 && cyc < 200) begin
            @(negedge clk);
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            #1;
            if (stall_pending) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_drop: got %b expected 1", out_valid); end
                checks++; if (out_data !== held) begin errors++; $display("FAIL bp_stable: got %h expected %h", out_data, held); end
            end
            if (out_valid && out_ready) begin
                e = sb_q.pop_front();
                checks++; if (out_data !== e.data) begin errors++; $display("FAIL bp_data: got %h expected %h", out_data, e.data); end
                checks++; if (out_last !== e.last) begin errors++; $display("FAIL bp_last: got %b expected %b", out_last, e.last); end
                $display("backpressure: word %0d data %h at cycle %0d", n_acc, out_data, cyc);
                n_acc++;
                stall_pending = 0;
            end else if (out_valid) begin
                stall_pending = 1;
                held = out_data;
            end
            cyc++;
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL bp_timeout: %0d words left expected 0", sb_q.size()); end
        sb_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (result_taken) taken_seen = 1;
        end
        checks++; if (!taken_seen) begin errors++; $display("FAIL bp_taken: got 0 expected 1"); end
        calc_done_flag = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_overrun;
        int cyc;
        int n_acc;
        int phase;
        exp_t e;
        cyc = 0;
        n_acc = 0;
        phase = 0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b expected 0", overrun); end
        load_matrix(16'h4000, 1'b1);
        out_ready = 1'b1;
        calc_done_flag = 1'b1;
        while (sb_q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            if (phase == 0 && n_acc == 3) begin
                calc_done_flag = 1'b0;
                phase = 1;
            end else if (phase == 1) begin
                load_matrix(16'h5000, 1'b0);
                calc_done_flag = 1'b1;
                phase = 2;
            end
            #1;
            if (out_valid && out_ready) begin
                e = sb_q.pop_front();
                checks++; if (out_data !== e.data) begin errors++; $display("FAIL ovr_data: got %h expected %h", out_data, e.data); end
                $display("overrun: word %0d data %h overrun %b", n_acc, out_data, overrun);
                n_acc++;
            end
            cyc++;
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL ovr_timeout: %0d words left expected 0", sb_q.size()); end
        sb_q.delete();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        calc_done_flag = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_no_restart: busy %b expected 0", busy); end
    endtask

    task automatic test_level_hold;
        int n_acc;
        int pulses;
        exp_t e;
        n_acc = 0;
        pulses = 0;
        load_matrix(16'h6000, 1'b1);
        out_ready = 1'b1;
        calc_done_flag = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk); #1;
            if (result_taken) pulses++;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL hold_extra_word: got %h expected none", out_data);
                end else begin
                    e = sb_q.pop_front();
                    checks++; if (out_data !== e.data) begin errors++; $display("FAIL hold_data: got %h expected %h", out_data, e.data); end
                end
                n_acc++;
            end
        end
        checks++; if (n_acc != 8) begin errors++; $display("FAIL hold_words: got %0d expected 8", n_acc); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL hold_taken: got %0d expected 1", pulses); end
        $display("level_hold: %0d words, %0d result_taken pulses", n_acc, pulses);
        sb_q.delete();
        calc_done_flag = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int cyc;
        int n_acc;
        bit taken_seen;
        exp_t e;
        cyc = 0;
        taken_seen = 0;
        load_matrix(16'h7000, 1'b1);
        out_ready = 1'b1;
        calc_done_flag = 1'b1;
        while (!taken_seen && cyc < 40) begin
            @(negedge clk);
            if (cyc == 2) calc_done_flag = 1'b0;
            #1;
            if (out_valid && out_ready && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++; if (out_data !== e.data) begin errors++; $display("FAIL b2b_first_data: got %h expected %h", out_data, e.data); end
            end
            if (result_taken) taken_seen = 1;
            cyc++;
        end
        checks++; if (!taken_seen) begin errors++; $display("FAIL b2b_first_taken: got 0 expected 1"); end
        sb_q.delete();
        // First cycle back in IDLE: raise the flag so the rise lands on the first IDLE edge.
        @(negedge clk);
        load_matrix(16'h7100, 1'b1);
        calc_done_flag = 1'b1;
        cyc = 0;
        n_acc = 0;
        while (sb_q.size() != 0 && cyc < 100) begin
            @(negedge clk); #1;
            if (out_valid && out_ready) begin
                e = sb_q.pop_front();
                checks++; if (out_data !== e.data) begin errors++; $display("FAIL b2b_data: got %h expected %h", out_data, e.data); end
                checks++; if (cyc != n_acc) begin errors++; $display("FAIL b2b_timing: word %0d at cycle %0d expected %0d", n_acc, cyc, n_acc); end
                $display("back_to_back: word %0d data %h", n_acc, out_data);
                n_acc++;
            end
            cyc++;
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_timeout: %0d words left expected 0", sb_q.size()); end
        sb_q.delete();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        calc_done_flag = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int cyc;
        int n_acc;
        exp_t e;
        cyc = 0;
        n_acc = 0;
        load_matrix(16'h8000, 1'b1);
        out_ready = 1'b1;
        calc_done_flag = 1'b1;
        while (n_acc < 4 && cyc < 50) begin
            @(negedge clk); #1;
            if (out_valid && out_ready) begin
                e = sb_q.pop_front();
                checks++; if (out_data !== e.data) begin errors++; $display("FAIL rstmid_data: got %h expected %h", out_data, e.data); end
                n_acc++;
            end
            cyc++;
        end
        checks++; if (n_acc != 4) begin errors++; $display("FAIL rstmid_timeout: got %0d words expected 4", n_acc); end
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid_data0: got %h expected 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rstmid_last: got %b expected 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (result_taken !== 1'b0) begin errors++; $display("FAIL rstmid_taken: got %b expected 0", result_taken); end
        $display("reset_mid: reset asserted after 4 words, valid %b busy %b", out_valid, busy);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        // Flag still high at release: no capture may happen.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b0 || result_taken !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_capture: valid %b taken %b expected 0 0", out_valid, result_taken);
            end
        end
        calc_done_flag = 1'b0;
        @(negedge clk);
        load_matrix(16'h9000, 1'b1);
        calc_done_flag = 1'b1;
        cyc = 0;
        n_acc = 0;
        while (sb_q.size() != 0 && cyc < 100) begin
            @(negedge clk); #1;
            if (out_valid && out_ready) begin
                e = sb_q.pop_front();
                checks++; if (out_data !== e.data) begin errors++; $display("FAIL rstmid_new_data: got %h expected %h", out_data, e.data); end
                $display("reset_mid: new stream word %0d data %h", n_acc, out_data);
                n_acc++;
            end
            cyc++;
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rstmid_new_timeout: %0d words left expected 0", sb_q.size()); end
        sb_q.delete();
        calc_done_flag = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        calc_done_flag = 1'b0;
        out_ready = 1'b1;
        in_c = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        apply_reset();
        test_level_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
